lif_layer: RTL and testbench

//   N_CH-channel leaky integrate-and-fire layer: per channel next = (state*beta)>>BETA_W + current.

---
 rtl/lif_layer.sv | 111 +++++++++++
 tb/tb_lif_layer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lif_layer.sv
`default_nettype none
// ============================================================================
//  Module      : lif_layer
//  Description : N_CH-channel leaky integrate-and-fire layer. Each channel
//                decays its membrane state by beta, adds its input current
//                with saturation, fires against a shared threshold and then
//                sits out a programmable number of refractory steps.
//                Everything advances only on the 'step' strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_layer #(
    parameter int N_CH     = 4,
    parameter int W        = 8,
    parameter int BETA_W   = 8,
    parameter int REFRAC_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    input  logic [N_CH*W-1:0]   current,
    input  logic [BETA_W-1:0]   beta,
    input  logic [W-1:0]        threshold,
    input  logic [REFRAC_W-1:0] refrac_cycles,
    input  logic                reset_mode,
    output logic [N_CH*W-1:0]   state,
    output logic [N_CH-1:0]     spike,
    output logic                any_spike,
    output logic [N_CH-1:0]     sat
);

    localparam logic [W-1:0]        c_state_max = '1;
    localparam logic [REFRAC_W-1:0] c_rc_one    = REFRAC_W'(1);

    // Registered per-channel state
    logic [W-1:0]        r_state [N_CH];
    logic [REFRAC_W-1:0] r_rc    [N_CH];
    logic [N_CH-1:0]     r_spike;
    logic [N_CH-1:0]     r_sat;
    logic                r_any_spike;

    // Next-state values, valid whenever step=1
    logic [W-1:0]        w_state_nxt [N_CH];
    logic [REFRAC_W-1:0] w_rc_nxt    [N_CH];
    logic [N_CH-1:0]     w_fire;
    logic [N_CH-1:0]     w_sat_nxt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [W+BETA_W-1:0] w_prod;
        logic [W-1:0]        w_leak;
        logic [W:0]          w_sum;
        logic [W-1:0]        w_sum_sat;
        logic                w_refrac;
        logic                w_ovf;

        // Full-width product; the top W bits are the decayed state and can
        // never exceed the current state because beta < 2^BETA_W.
        assign w_prod    = {{BETA_W{1'b0}}, r_state[i]} * {{W{1'b0}}, beta};
        assign w_leak    = w_prod[W+BETA_W-1:BETA_W];
        assign w_refrac  = (r_rc[i] != '0);

        // One extra bit catches the overflow that drives the sticky sat flag
        assign w_sum     = {1'b0, w_leak} + {1'b0, current[i*W +: W]};
        assign w_ovf     = w_sum[W];
        assign w_sum_sat = w_ovf ? c_state_max : w_sum[W-1:0];

        // A refractory channel only leaks; its current is ignored entirely
        assign w_fire[i] = !w_refrac && (threshold != '0) && (w_sum_sat >= threshold);

        assign w_state_nxt[i] = w_refrac  ? w_leak :
                                w_fire[i] ? (reset_mode ? (w_sum_sat - threshold) : '0) :
                                            w_sum_sat;

        // Counter is loaded only on a fire, so a config change mid-count has no effect
        assign w_rc_nxt[i]    = w_refrac  ? (r_rc[i] - c_rc_one) :
                                w_fire[i] ? refrac_cycles : '0;

        assign w_sat_nxt[i]   = r_sat[i] | (!w_refrac & w_ovf);

        assign state[i*W +: W] = r_state[i];
    end : g_ch

    // Advance all channels on step; otherwise hold state and drop the spike pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                r_state[k] <= '0;
                r_rc[k]    <= '0;
            end
            r_spike     <= '0;
            r_sat       <= '0;
            r_any_spike <= 1'b0;
        end else if (step) begin
            for (int k = 0; k < N_CH; k++) begin
                r_state[k] <= w_state_nxt[k];
                r_rc[k]    <= w_rc_nxt[k];
            end
            r_spike     <= w_fire;
            r_sat       <= w_sat_nxt;
            r_any_spike <= |w_fire;
        end else begin
            r_spike     <= '0;
            r_any_spike <= 1'b0;
        end
    end

    assign spike     = r_spike;
    assign any_spike = r_any_spike;
    assign sat       = r_sat;

endmodule : lif_layer
`default_nettype wire

// File: tb/tb_lif_layer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_layer
//  Description : Self-checking bench for lif_layer. An integer-arithmetic
//                neuron model is compared against every output on every
//                falling edge; directed sequences also pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_layer;

    localparam int N_CH     = 4;
    localparam int W        = 8;
    localparam int BETA_W   = 8;
    localparam int REFRAC_W = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                step;
    logic [N_CH*W-1:0]   current;
    logic [BETA_W-1:0]   beta;
    logic [W-1:0]        threshold;
    logic [REFRAC_W-1:0] refrac_cycles;
    logic                reset_mode;
    logic [N_CH*W-1:0]   state;
    logic [N_CH-1:0]     spike;
    logic                any_spike;
    logic [N_CH-1:0]     sat;

    int n_tests = 0;
    int n_fail  = 0;

    lif_layer #(
        .N_CH(N_CH), .W(W), .BETA_W(BETA_W), .REFRAC_W(REFRAC_W)
    ) dut (
        .clk(clk), .reset(reset), .step(step), .current(current), .beta(beta),
        .threshold(threshold), .refrac_cycles(refrac_cycles), .reset_mode(reset_mode),
        .state(state), .spike(spike), .any_spike(any_spike), .sat(sat)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural neuron model ----------------
    int m_state [N_CH];
    int m_rc    [N_CH];
    bit m_spike [N_CH];
    bit m_sat   [N_CH];
    bit m_any;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                m_state[c] = 0; m_rc[c] = 0; m_spike[c] = 0; m_sat[c] = 0;
            end
            m_any = 0;
        end else if (!step) begin
            for (int c = 0; c < N_CH; c++) m_spike[c] = 0;
            m_any = 0;
        end else begin
            m_any = 0;
            for (int c = 0; c < N_CH; c++) begin
                int leak, sum;
                leak = (m_state[c] * int'(beta)) / (1 << BETA_W);
                if (m_rc[c] > 0) begin
                    m_state[c] = leak;
                    m_rc[c]    = m_rc[c] - 1;
                    m_spike[c] = 0;
                end else begin
                    sum = leak + int'(current[c*W +: W]);
                    if (sum > (1 << W) - 1) begin
                        sum = (1 << W) - 1;
                        m_sat[c] = 1;
                    end
                    if (threshold != 0 && sum >= int'(threshold)) begin
                        m_spike[c] = 1;
                        m_rc[c]    = int'(refrac_cycles);
                        m_state[c] = reset_mode ? sum - int'(threshold) : 0;
                    end else begin
                        m_spike[c] = 0;
                        m_state[c] = sum;
                    end
                end
                m_any = m_any | m_spike[c];
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        logic [N_CH*W-1:0] exp_state;
        logic [N_CH-1:0]   exp_spike, exp_sat;
        for (int c = 0; c < N_CH; c++) begin
            exp_state[c*W +: W] = W'(m_state[c]);
            exp_spike[c]        = m_spike[c];
            exp_sat[c]          = m_sat[c];
        end
        n_tests += 4;
        if (state !== exp_state) begin
            n_fail++;
            $display("FAIL model_state t=%0t got=%h exp=%h", $time, state, exp_state);
        end
        if (spike !== exp_spike) begin
            n_fail++;
            $display("FAIL model_spike t=%0t got=%b exp=%b", $time, spike, exp_spike);
        end
        if (any_spike !== m_any) begin
            n_fail++;
            $display("FAIL model_any t=%0t got=%b exp=%b", $time, any_spike, m_any);
        end
        if (sat !== exp_sat) begin
            n_fail++;
            $display("FAIL model_sat t=%0t got=%b exp=%b", $time, sat, exp_sat);
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Advance one clock; inputs always change 2 time units after a rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic int ch(input int c);
        return int'(state[c*W +: W]);
    endfunction

    // ---------------- directed stimulus ----------------
    int exp_leak [5] = '{100, 50, 25, 12, 6};
    int exp_fz   [4] = '{100, 0, 100, 0};
    int exp_fzs  [4] = '{0, 1, 0, 1};
    int exp_sr   [4] = '{50, 25, 12, 56};
    int exp_srs  [4] = '{1, 0, 0, 1};

    initial begin
        reset = 1'b1; step = 1'b1; current = {N_CH{8'd77}};
        beta = 8'd128; threshold = 8'd10; refrac_cycles = '0; reset_mode = 1'b0;
        #2;

        // 1. reset held with activity on the inputs
        tick(); tick();
        lit("rst_state", int'(state), 0);
        lit("rst_spike", int'(spike), 0);
        lit("rst_sat", int'(sat), 0);
        reset = 1'b0;

        // 2. leak only on ch0
        do_reset();
        step = 1'b1; threshold = 8'd0; beta = 8'd128;
        current = '0; current[7:0] = 8'd100;
        for (int k = 0; k < 5; k++) begin
            tick();
            current = '0;
            lit($sformatf("leak_state%0d", k), ch(0), exp_leak[k]);
            lit($sformatf("leak_spike%0d", k), int'(spike), 0);
        end

        // 3. fire with reset-to-zero
        do_reset();
        threshold = 8'd150; reset_mode = 1'b0; refrac_cycles = '0;
        current[7:0] = 8'd100;
        for (int k = 0; k < 4; k++) begin
            tick();
            lit($sformatf("fz_state%0d", k), ch(0), exp_fz[k]);
            lit($sformatf("fz_spike%0d", k), int'(spike[0]), exp_fzs[k]);
        end

        // 4. subtract reset with 2-step refractory
        do_reset();
        reset_mode = 1'b1; refrac_cycles = 4'd2; current[7:0] = 8'd200;
        for (int k = 0; k < 4; k++) begin
            tick();
            lit($sformatf("sr_state%0d", k), ch(0), exp_sr[k]);
            lit($sformatf("sr_spike%0d", k), int'(spike[0]), exp_srs[k]);
        end

        // 5. saturation, then full leak with beta=0
        do_reset();
        beta = 8'd255; threshold = 8'd0; refrac_cycles = '0; reset_mode = 1'b0;
        current[7:0] = 8'd200;
        tick(); lit("sat_s1", ch(0), 200); lit("sat_f1", int'(sat[0]), 0);
        tick(); lit("sat_s2", ch(0), 255); lit("sat_f2", int'(sat[0]), 1);
        current[7:0] = 8'd0;
        tick(); lit("sat_s3", ch(0), 254); lit("sat_sticky", int'(sat[0]), 1);

        // 6a. step gating: everything holds for 5 cycles
        step = 1'b0; current[7:0] = 8'd90;
        for (int k = 0; k < 5; k++) tick();
        lit("gate_state", ch(0), 254);
        lit("gate_spike", int'(spike), 0);
        lit("gate_sat", int'(sat[0]), 1);
        step = 1'b1; beta = 8'd0; current = '0;
        tick(); lit("beta0_leak", ch(0), 0);

        // 6b. only ch2 driven above threshold
        do_reset();
        beta = 8'd128; threshold = 8'd50; current = '0; current[2*W +: W] = 8'd100;
        tick();
        lit("ind_spike", int'(spike), 4);
        lit("ind_any", int'(any_spike), 1);
        lit("ind_ch1", ch(1), 0);
        step = 1'b0;
        tick();
        lit("ind_pulse_end", int'(spike), 0);
        lit("ind_any_end", int'(any_spike), 0);

        // mixed activity on all channels for the model compare
        step = 1'b1; threshold = 8'd120; refrac_cycles = 4'd1; reset_mode = 1'b1; beta = 8'd200;
        for (int k = 0; k < 20; k++) begin
            current = {8'(k * 37 + 11), 8'(k * 53), 8'(255 - k * 9), 8'(k * 13)};
            step    = (k % 4) != 3;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lif_layer
`default_nettype wire
